// File: rtl/pn_acq_ctrl_if.sv
// PN acquisition control bus: correlator results in, PN generator load command and status out.
// Combinational bundle only; no latency of its own.
// No backpressure: dump is a strobe and load is a one-cycle command.
interface pn_acq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int E_W    = 36
);
  logic              enable;
  logic              dump;
  logic [E_W-1:0]    energy;
  logic [E_W-1:0]    e_early;
  logic [E_W-1:0]    e_late;
  logic [E_W-1:0]    gate;
  logic              load;
  logic [ADDR_W-1:0] addr_load;
  logic              locked;
  logic [1:0]        state;
  logic              sweep_done;

  // Correlator / host side
  modport master (
    output enable, dump, energy, e_early, e_late, gate,
    input  load, addr_load, locked, state, sweep_done
  );

  // Acquisition controller side
  modport slave (
    input  enable, dump, energy, e_early, e_late, gate,
    output load, addr_load, locked, state, sweep_done
  );
endinterface

// File: rtl/pn_acq_ctrl.sv
// Serial-search PN acquisition: search, verify, then early/late track of the code phase.
// All outputs update exactly one clock after the dump (or enable change) that causes them.
// No backpressure: every dump is consumed in its own cycle; enable=0 overrides a dump.
module pn_acq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int PN_LEN   = 255,
  parameter int E_W      = 36,
  parameter int VERIFY_N = 3,
  parameter int MISS_N   = 4
) (
  input  logic              clk,
  input  logic              rst,
  pn_acq_ctrl_if.slave      acq
);

  localparam int HIT_W  = $clog2(VERIFY_N + 1);
  localparam int MISS_W = $clog2(MISS_N + 1);
  localparam logic [ADDR_W-1:0] LAST_PH = ADDR_W'(PN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    TRACK  = 2'd3
  } state_t;

  state_t             r_state, w_state_nx;
  logic [ADDR_W-1:0]  r_phase, w_phase_nx;
  logic [ADDR_W-1:0]  r_addr,  w_addr_nx;
  logic [HIT_W-1:0]   r_hit_cnt, w_hit_nx;
  logic [MISS_W-1:0]  r_miss_cnt, w_miss_nx;
  logic               r_load, w_load_nx;
  logic               r_sweep, w_sweep_nx;
  logic               r_locked;
  logic               w_slip, w_adj, w_fwd, w_back;

  // Strict unsigned detection: equality counts as a miss
  logic w_hit;
  assign w_hit = acq.energy > acq.gate;

  // Early/late discriminator with a gate/4 dead zone, one extra bit so sums never overflow
  logic [E_W:0] w_early_x, w_late_x, w_dz, w_early_thr, w_late_thr;
  assign w_early_x   = {1'b0, acq.e_early};
  assign w_late_x    = {1'b0, acq.e_late};
  assign w_dz        = {3'b000, acq.gate[E_W-1:2]};
  assign w_early_thr = w_early_x + w_dz;
  assign w_late_thr  = w_late_x + w_dz;
  assign w_back      = w_early_x > w_late_thr;
  assign w_fwd       = w_late_x > w_early_thr;

  function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PH) ? '0 : p + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] f_dec(input logic [ADDR_W-1:0] p);
    return (p == '0) ? LAST_PH : p - ADDR_W'(1);
  endfunction

  // Next-state, counter and phase-command logic
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_addr_nx  = r_addr;
    w_hit_nx   = r_hit_cnt;
    w_miss_nx  = r_miss_cnt;
    w_load_nx  = 1'b0;
    w_sweep_nx = 1'b0;
    w_slip     = 1'b0;
    w_adj      = 1'b0;

    if (!acq.enable) begin
      w_state_nx = IDLE;
      w_hit_nx   = '0;
      w_miss_nx  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nx = SEARCH;
          w_phase_nx = '0;
          w_hit_nx   = '0;
          w_miss_nx  = '0;
        end
        SEARCH: begin
          if (acq.dump) begin
            if (w_hit) begin
              w_state_nx = VERIFY;
              w_hit_nx   = HIT_W'(1);
            end else begin
              w_slip = 1'b1;
            end
          end
        end
        VERIFY: begin
          if (acq.dump) begin
            if (w_hit) begin
              if (r_hit_cnt >= HIT_W'(VERIFY_N - 1)) begin
                w_state_nx = TRACK;
                w_hit_nx   = HIT_W'(VERIFY_N);
                w_miss_nx  = '0;
              end else begin
                w_hit_nx = r_hit_cnt + HIT_W'(1);
              end
            end else begin
              w_state_nx = SEARCH;
              w_hit_nx   = '0;
              w_slip     = 1'b1;
            end
          end
        end
        TRACK: begin
          if (acq.dump) begin
            if (w_hit) begin
              w_miss_nx = '0;
              w_adj     = 1'b1;
            end else if (r_miss_cnt >= MISS_W'(MISS_N - 1)) begin
              w_state_nx = SEARCH;
              w_miss_nx  = '0;
              w_hit_nx   = '0;
              w_slip     = 1'b1;
            end else begin
              w_miss_nx = r_miss_cnt + MISS_W'(1);
              w_adj     = 1'b1;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end

    // Any phase change is also a load command to the PN generator
    if (w_slip) begin
      w_phase_nx = f_inc(r_phase);
      w_sweep_nx = (r_phase == LAST_PH);
    end else if (w_adj && w_back) begin
      w_phase_nx = f_dec(r_phase);
    end else if (w_adj && w_fwd) begin
      w_phase_nx = f_inc(r_phase);
    end
    if (w_slip || (w_adj && (w_back || w_fwd))) begin
      w_addr_nx = w_phase_nx;
      w_load_nx = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_addr     <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_load     <= 1'b0;
      r_sweep    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_addr     <= w_addr_nx;
      r_hit_cnt  <= w_hit_nx;
      r_miss_cnt <= w_miss_nx;
      r_load     <= w_load_nx;
      r_sweep    <= w_sweep_nx;
      r_locked   <= (w_state_nx == TRACK);
    end
  end

  assign acq.load       = r_load;
  assign acq.addr_load  = r_addr;
  assign acq.locked     = r_locked;
  assign acq.state      = r_state;
  assign acq.sweep_done = r_sweep;

endmodule

// File: doc/pn_acq_ctrl.md
PN_ACQ_CTRL -- requirements
Module: pn_acq_ctrl

Interface
REQ-001 Parameter ADDR_W, 8, width of PN phase address.
REQ-002 Parameter PN_LEN, 255, PN code length in chips; legal phase range 0..PN_LEN-1.
REQ-003 Parameter E_W, 36, width of correlation energy and threshold inputs.
REQ-004 Parameter VERIFY_N, 3, consecutive above-threshold dumps required to declare lock.
REQ-005 Parameter MISS_N, 4, consecutive below-threshold dumps required to drop lock.
REQ-006 clk  input  1  system clock, 49.6 MHz; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  acquisition enable, level.
REQ-009 dump  input  1  one-cycle strobe marking the end of one correlation integration period.
REQ-010 energy  input  E_W  unsigned prompt-branch energy (I^2+Q^2); valid only in the dump cycle.
REQ-011 e_early  input  E_W  unsigned early-branch energy; valid only in the dump cycle.
REQ-012 e_late  input  E_W  unsigned late-branch energy; valid only in the dump cycle.
REQ-013 gate  input  E_W  unsigned detection threshold; quasi-static.
REQ-014 load  output  1  one-cycle pulse commanding the PN generator to jump to addr_load.
REQ-015 addr_load  output  ADDR_W  PN phase to load; held stable between load pulses.
REQ-016 locked  output  1  high while in TRACK.
REQ-017 state  output  2  current state encoding: IDLE=0, SEARCH=1, VERIFY=2, TRACK=3.
REQ-018 sweep_done  output  1  one-cycle pulse when a SEARCH slip wraps phase from PN_LEN-1 to 0.

Function
REQ-019 Detection compare is unsigned and strict: hit = energy > gate; energy == gate is a miss.
REQ-020 IDLE: when enable=1, go to SEARCH at the next edge with phase=0 and no load pulse.
REQ-021 SEARCH, dump with hit: go to VERIFY, hit_cnt=1, phase unchanged.
REQ-022 SEARCH, dump with miss: slip phase by +1; PN_LEN-1 wraps to 0, and that wrap pulses sweep_done.
REQ-023 VERIFY, dump with hit: increment hit_cnt; on reaching VERIFY_N, go to TRACK with miss_cnt=0.
REQ-024 VERIFY, dump with miss: return to SEARCH with a +1 slip, following the REQ-022 wrap rule.
REQ-025 TRACK, dump with hit: clear miss_cnt.
REQ-026 TRACK, dump with miss: increment miss_cnt; on reaching MISS_N, go to SEARCH with a +1 slip and locked=0.
REQ-027 TRACK, dump with no loss of lock, e_early > e_late + (gate>>2): decrement phase; 0 wraps to PN_LEN-1.
REQ-028 TRACK, dump with no loss of lock, e_late > e_early + (gate>>2): increment phase; PN_LEN-1 wraps to 0.
REQ-029 TRACK, dump with no loss of lock, neither REQ-027 nor REQ-028 true: no phase change.
REQ-030 Early/late sums are computed at E_W+1 bits with no overflow.
REQ-031 Every phase change is registered: addr_load takes the new value and load=1 in the cycle after the dump; load is 0 otherwise.
REQ-032 Latency from dump to state, counter, locked and load update is exactly 1 clock.
REQ-033 A dump with enable=0 is ignored.
REQ-034 enable=0 in any state: go to IDLE at the next edge; clear locked and all counters; addr_load retains its value; no load pulse.
REQ-035 enable=0 has priority over a simultaneous dump.
REQ-036 A dump arriving in the same cycle as a load pulse is processed normally.
REQ-037 Counters saturate at their terminal values and never wrap.
REQ-038 locked is registered and equals (state == TRACK).

Reset
REQ-039 rst=0 forces immediately, without waiting for clk: state=IDLE, load=0, addr_load=0, locked=0, sweep_done=0, hit_cnt=0, miss_cnt=0.
REQ-040 Reset asserted mid-operation discards any in-flight dump.
REQ-041 After rst deasserts, operation resumes at the first clk edge with enable sampled.

Verification
REQ-042 Reset, then enable=1, gate=1000, 10 dumps with energy=500 -> load pulses with addr_load 1..10, state=1, locked=0.
REQ-043 Phase at 254, one miss dump (PN_LEN=255) -> addr_load=0, load=1, sweep_done=1 in the same cycle.
REQ-044 energy=1001 for 3 dumps (gate=1000) -> state 1->2->2->3, locked=1 one cycle after the 3rd dump, no load pulse.
REQ-044 energy=1000, i.e. equal to gate, in SEARCH -> counted as a miss and slips.
REQ-045 TRACK at phase 5, gate=1000: e_early=600, e_late=300 -> addr_load=4; e_early=e_late=300 -> no load.
REQ-046 TRACK, 4 consecutive miss dumps -> locked drops and state=1 after the 4th, addr_load=phase+1; a hit after 3 misses keeps lock.
REQ-047 Async rst pulse mid-VERIFY between clk edges -> all outputs zero immediately; enable=0 during a dump -> IDLE, no load pulse.
